// File: rtl/ram_clear_ctrl.sv
// Background clear of SDRAM and DDR3 after core start: two concurrent write channels
// plus busy/done/progress status. Define RAM_CLEAR_PATTERN_EN for address-derived test data.
module ram_clear_ctrl #(
  parameter int SDR_AW    = 25,
  parameter int DDR_AW    = 29,
  parameter int DDR_BURST = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              init,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic [15:0]       sdr_din,
  output logic              sdr_we,
  input  logic              sdr_ready,
  output logic [DDR_AW-1:0] ddr_addr,
  output logic [7:0]        ddr_burstcnt,
  output logic [63:0]       ddr_din,
  output logic [7:0]        ddr_be,
  output logic              ddr_we,
  input  logic              ddr_busy,
  output logic              busy,
  output logic              done,
  output logic [7:0]        progress
);

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_e;
  typedef enum logic [2:0] {C_IDLE, C_REQ, C_WAIT, C_BURST, C_DONE} chan_state_e;

  localparam logic [7:0]        BEAT_LAST  = 8'(DDR_BURST - 1);
  localparam logic [SDR_AW:0]   SDR_STEP   = (SDR_AW + 1)'(1);
  localparam logic [DDR_AW:0]   DDR_STEP   = (DDR_AW + 1)'(DDR_BURST);

  top_state_e  top_q;
  chan_state_e sdr_st_q, ddr_st_q;
  // Counters are one bit wider than the address; the MSB flags a full wrap.
  logic [SDR_AW:0] sdr_cnt_q, sdr_cnt_d;
  logic [DDR_AW:0] ddr_base_q, ddr_base_d;
  logic [7:0]      beat_q;
  logic            sdr_we_q, ddr_we_q;

  assign sdr_cnt_d  = sdr_cnt_q + SDR_STEP;
  assign ddr_base_d = ddr_base_q + DDR_STEP;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      top_q      <= T_IDLE;
      sdr_st_q   <= C_IDLE;
      ddr_st_q   <= C_IDLE;
      sdr_cnt_q  <= '0;
      ddr_base_q <= '0;
      beat_q     <= '0;
      sdr_we_q   <= 1'b0;
      ddr_we_q   <= 1'b0;
    end else if (init) begin
      top_q      <= T_IDLE;
      sdr_st_q   <= C_IDLE;
      ddr_st_q   <= C_IDLE;
      sdr_cnt_q  <= '0;
      ddr_base_q <= '0;
      beat_q     <= '0;
      sdr_we_q   <= 1'b0;
      ddr_we_q   <= 1'b0;
    end else begin
      case (top_q)
        T_IDLE, T_DONE: begin
          if (start) begin
            top_q      <= T_RUN;
            sdr_st_q   <= C_REQ;
            sdr_we_q   <= 1'b1;
            sdr_cnt_q  <= '0;
            ddr_st_q   <= C_BURST;
            ddr_we_q   <= 1'b1;
            ddr_base_q <= '0;
            beat_q     <= '0;
          end
        end
        T_RUN: begin
          if (sdr_st_q == C_DONE && ddr_st_q == C_DONE) top_q <= T_DONE;

          case (sdr_st_q)
            C_REQ: begin
              sdr_we_q <= 1'b0;
              sdr_st_q <= C_WAIT;
            end
            C_WAIT: begin
              if (sdr_ready) begin
                sdr_cnt_q <= sdr_cnt_d;
                if (sdr_cnt_d[SDR_AW]) begin
                  sdr_st_q <= C_DONE;
                end else begin
                  sdr_st_q <= C_REQ;
                  sdr_we_q <= 1'b1;
                end
              end
            end
            default: ;
          endcase

          // Waitrequest freezes the burst; the base only moves after the last beat.
          if (ddr_st_q == C_BURST && !ddr_busy) begin
            if (beat_q == BEAT_LAST) begin
              beat_q     <= '0;
              ddr_base_q <= ddr_base_d;
              if (ddr_base_d[DDR_AW]) begin
                ddr_we_q <= 1'b0;
                ddr_st_q <= C_DONE;
              end
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        default: top_q <= T_IDLE;
      endcase
    end
  end

  assign sdr_addr     = sdr_cnt_q[SDR_AW-1:0];
  assign sdr_we       = sdr_we_q;
  assign ddr_addr     = ddr_base_q[DDR_AW-1:0];
  assign ddr_we       = ddr_we_q;
  assign ddr_burstcnt = 8'(DDR_BURST);
  assign ddr_be       = 8'hFF;
  assign busy         = (top_q == T_RUN);
  assign done         = (top_q == T_DONE);

  // Fractions scaled to 256 = complete; 9 bits so a finished channel reads as 1.0.
  logic [8:0] sdr_frac, ddr_frac, min_frac;
  assign sdr_frac = 9'({sdr_cnt_q, 8'd0} >> SDR_AW);
  assign ddr_frac = 9'({ddr_base_q, 8'd0} >> DDR_AW);

  always_comb begin
    min_frac = (sdr_frac < ddr_frac) ? sdr_frac : ddr_frac;
    progress = 8'h00;
    if (top_q == T_DONE)     progress = 8'hFF;
    else if (top_q == T_RUN) progress = min_frac[8] ? 8'hFF : min_frac[7:0];
  end

`ifdef RAM_CLEAR_PATTERN_EN
  logic [31:0] ddr_word;
  assign ddr_word = 32'(ddr_base_q[DDR_AW-1:0]) + 32'(beat_q);
  assign sdr_din  = busy ? (16'(sdr_cnt_q[SDR_AW-1:0]) ^ 16'hA5A5) : 16'h0000;
  assign ddr_din  = busy ? {ddr_word, ddr_word} : 64'h0;
`else
  assign sdr_din = 16'h0000;
  assign ddr_din = 64'h0;
`endif

endmodule
